// File: rtl/hm_pkg.sv
// Shared register offsets and STATUS bit positions for the HM CSR front-end.
// Constants only: no latency, no flow control.
package hm_pkg;
  localparam int HM_STATUS_W = 7;

  localparam logic [3:0] HM_REG_STATUS   = 4'h0;
  localparam logic [3:0] HM_REG_IRQ_MASK = 4'h1;
  localparam logic [3:0] HM_REG_BAR_BMP  = 4'h2;
  localparam logic [3:0] HM_REG_STATE    = 4'h3;
  localparam logic [3:0] HM_REG_CPT_RX   = 4'h4;
  localparam logic [3:0] HM_REG_CPT_TX   = 4'h5;
  localparam logic [3:0] HM_REG_CPT_DROP = 4'h6;
  localparam logic [3:0] HM_REG_LAST_BAR = 4'h7;
  localparam logic [3:0] HM_REG_EVT_CNT  = 4'h8;

  localparam int HM_ST_RX_TO     = 0;
  localparam int HM_ST_TX_TO     = 1;
  localparam int HM_ST_WR_TO     = 2;
  localparam int HM_ST_HM_END    = 3;
  localparam int HM_ST_WRITE_BAR = 4;
  localparam int HM_ST_READ_EXP  = 5;
  localparam int HM_ST_LINK_CHG  = 6;
endpackage

// File: rtl/hm_ctlif_if.sv
// CSR bus between the register master and the HM control front-end.
// Read data is registered by the slave one cycle after the address; no backpressure.
interface hm_ctlif_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/hm_stable_snap.sv
// Captures a multi-bit value only once it has held for two consecutive samples.
// Latency: a stable input is visible 2 cycles after it arrives; no backpressure.
module hm_stable_snap #(
  parameter int W = 32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] snap
);
  logic [W-1:0] dly;

  // A value that differs from last cycle's may be a skewed mix of old and new bits.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dly  <= '0;
      snap <= '0;
    end else begin
      dly <= din;
      if (din == dly) snap <= din;
    end
  end
endmodule

// File: rtl/hm_ctlif.sv
// CSR front-end for the HM core: sticky status, masked irq, counter snapshots, BAR bitmap.
// Latency: read data and irq 1 cycle; writes take effect at the strobe edge; no backpressure.
module hm_ctlif
  import hm_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         EVT_W    = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  hm_ctlif_if.slave   csr,
  output logic        irq,
  input  logic        sys__rx_timeout,
  input  logic        sys__tx_timeout,
  input  logic        sys__wr_timeout,
  input  logic        sys__hm_end,
  input  logic        sys__write_bar,
  input  logic        sys__read_exp,
  input  logic        sys__trn_lnk_up_n,
  input  logic [2:0]  sys__state_rx,
  input  logic [1:0]  sys__state_tx,
  input  logic [1:0]  sys__state,
  input  logic [31:0] sys__stat_trn_cpt_rx,
  input  logic [31:0] sys__stat_trn_cpt_tx,
  input  logic [31:0] sys__stat_trn_cpt_drop,
  input  logic [4:0]  sys__write_bar_number,
  output logic [31:0] sys__bar_bitmap
);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [HM_STATUS_W-1:0] status, irq_mask, set_vec, clr_vec;
  logic [4:0]             last_bar;
  logic [EVT_W-1:0]       evt_cnt;
  logic                   lnk_prev;
  logic [31:0]            snap_rx, snap_tx, snap_drop, rd_dat;
  logic                   bank_sel, wr_hit, any_to;
  logic [3:0]             off;
  logic                   unused_addr;

  assign bank_sel    = (csr.csr_a[13:10] == csr_addr);
  assign off         = csr.csr_a[3:0];
  assign wr_hit      = csr.csr_we && bank_sel;
  assign any_to      = sys__rx_timeout | sys__tx_timeout | sys__wr_timeout;
  assign unused_addr = ^csr.csr_a[9:4];

  always_comb begin
    set_vec                  = '0;
    set_vec[HM_ST_RX_TO]     = sys__rx_timeout;
    set_vec[HM_ST_TX_TO]     = sys__tx_timeout;
    set_vec[HM_ST_WR_TO]     = sys__wr_timeout;
    set_vec[HM_ST_HM_END]    = sys__hm_end;
    set_vec[HM_ST_WRITE_BAR] = sys__write_bar;
    set_vec[HM_ST_READ_EXP]  = sys__read_exp;
    set_vec[HM_ST_LINK_CHG]  = (sys__trn_lnk_up_n != lnk_prev);
    clr_vec = (wr_hit && off == HM_REG_STATUS) ? csr.csr_di[HM_STATUS_W-1:0] : '0;
  end

  always_comb begin
    rd_dat = '0;
    case (off)
      HM_REG_STATUS:   rd_dat = {{(32-HM_STATUS_W){1'b0}}, status};
      HM_REG_IRQ_MASK: rd_dat = {{(32-HM_STATUS_W){1'b0}}, irq_mask};
      HM_REG_BAR_BMP:  rd_dat = sys__bar_bitmap;
      HM_REG_STATE:    rd_dat = {24'b0, sys__trn_lnk_up_n, sys__state_rx, sys__state_tx, sys__state};
      HM_REG_CPT_RX:   rd_dat = snap_rx;
      HM_REG_CPT_TX:   rd_dat = snap_tx;
      HM_REG_CPT_DROP: rd_dat = snap_drop;
      HM_REG_LAST_BAR: rd_dat = {27'b0, last_bar};
      HM_REG_EVT_CNT:  rd_dat = 32'(evt_cnt);
      default:         rd_dat = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr.csr_do      <= '0;
      irq             <= 1'b0;
      sys__bar_bitmap <= '0;
      status          <= '0;
      irq_mask        <= '0;
      last_bar        <= '0;
      evt_cnt         <= '0;
      lnk_prev        <= 1'b1;
    end else begin
      csr.csr_do <= bank_sel ? rd_dat : 32'h0;
      irq        <= |(status & irq_mask);
      lnk_prev   <= sys__trn_lnk_up_n;
      // Set is OR'd after the clear so a simultaneous event is never lost.
      status     <= (status & ~clr_vec) | set_vec;
      if (wr_hit && off == HM_REG_IRQ_MASK) irq_mask <= csr.csr_di[HM_STATUS_W-1:0];
      if (wr_hit && off == HM_REG_BAR_BMP) sys__bar_bitmap <= csr.csr_di;
      if (sys__write_bar) last_bar <= sys__write_bar_number;
      if (wr_hit && off == HM_REG_EVT_CNT) evt_cnt <= any_to ? EVT_W'(1) : '0;
      else if (any_to && evt_cnt != EVT_MAX) evt_cnt <= evt_cnt + 1'b1;
    end
  end

  hm_stable_snap #(.W(32)) u_snap_rx (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(sys__stat_trn_cpt_rx), .snap(snap_rx)
  );
  hm_stable_snap #(.W(32)) u_snap_tx (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(sys__stat_trn_cpt_tx), .snap(snap_tx)
  );
  hm_stable_snap #(.W(32)) u_snap_drop (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(sys__stat_trn_cpt_drop), .snap(snap_drop)
  );
endmodule

// File: tb/tb_hm_ctlif.sv
// Bench for hm_ctlif: directed vector table, hand sequences for EVT_CNT, then random
// traffic against a cycle-level reference model of the register map.
module tb_hm_ctlif;
  localparam logic [3:0] BANK  = 4'h2;
  localparam int         EVT_W = 4;
  localparam int         EVT_MAX = (1 << EVT_W) - 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        irq;
  logic        rx_to, tx_to, wr_to, hm_end, write_bar, read_exp, lnk_n;
  logic [2:0]  st_rx;
  logic [1:0]  st_tx, st;
  logic [31:0] cpt_rx, cpt_tx, cpt_drop, bar_bitmap;
  logic [4:0]  bar_num;

  hm_ctlif_if ifc ();

  hm_ctlif #(.csr_addr(BANK), .EVT_W(EVT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr(ifc.slave), .irq(irq),
    .sys__rx_timeout(rx_to), .sys__tx_timeout(tx_to), .sys__wr_timeout(wr_to),
    .sys__hm_end(hm_end), .sys__write_bar(write_bar), .sys__read_exp(read_exp),
    .sys__trn_lnk_up_n(lnk_n), .sys__state_rx(st_rx), .sys__state_tx(st_tx),
    .sys__state(st), .sys__stat_trn_cpt_rx(cpt_rx), .sys__stat_trn_cpt_tx(cpt_tx),
    .sys__stat_trn_cpt_drop(cpt_drop), .sys__write_bar_number(bar_num),
    .sys__bar_bitmap(bar_bitmap)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [6:0]  m_st, m_mk;
  logic [31:0] m_bmp;
  logic [4:0]  m_lb;
  int          m_evt;
  logic        m_lp;
  logic [31:0] m_prev [3];
  logic [31:0] m_snap [3];

  typedef struct {
    logic [3:0]  off;
    logic        hit;
    logic        we;
    logic [31:0] di;
    logic [5:0]  pul;   // {read_exp, write_bar, hm_end, wr_to, tx_to, rx_to}
    logic        lnk;
    logic [31:0] rx;
    logic        chk_do;
    logic [31:0] exp_do;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t tv [64];
  int   nv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] off, input logic hit, input logic we, input logic [31:0] di,
                     input logic [5:0] pul, input logic lnk, input logic [31:0] rx,
                     input logic cd, input logic [31:0] ed, input logic ci, input logic ei);
    tv[nv] = '{off, hit, we, di, pul, lnk, rx, cd, ed, ci, ei};
    nv++;
  endtask

  task automatic set_bus(input logic [3:0] off, input logic hit, input logic we, input logic [31:0] di);
    ifc.csr_a  = {(hit ? BANK : ~BANK), 6'h0, off};
    ifc.csr_we = we;
    ifc.csr_di = di;
  endtask

  task automatic set_pul(input logic [5:0] p);
    {read_exp, write_bar, hm_end, wr_to, tx_to, rx_to} = p;
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] off);
    case (off)
      4'h0: return {25'b0, m_st};
      4'h1: return {25'b0, m_mk};
      4'h2: return m_bmp;
      4'h3: return {24'b0, lnk_n, st_rx, st_tx, st};
      4'h4: return m_snap[0];
      4'h5: return m_snap[1];
      4'h6: return m_snap[2];
      4'h7: return {27'b0, m_lb};
      4'h8: return 32'(m_evt);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: predict from the inputs currently driven, advance, compare.
  task automatic cyc();
    logic [31:0] e_do, cnt_in [3];
    logic        e_irq, hit, wr, any;
    logic [3:0]  off;
    hit = (ifc.csr_a[13:10] == BANK);
    off = ifc.csr_a[3:0];
    wr  = ifc.csr_we && hit;
    any = rx_to | tx_to | wr_to;
    cnt_in = '{cpt_rx, cpt_tx, cpt_drop};
    if (sys_rst) begin
      e_do = 0; e_irq = 0;
      m_st = 0; m_mk = 0; m_bmp = 0; m_lb = 0; m_evt = 0; m_lp = 1'b1;
      for (int k = 0; k < 3; k++) begin m_prev[k] = 0; m_snap[k] = 0; end
    end else begin
      e_do  = hit ? model_rd(off) : 32'h0;
      e_irq = |(m_st & m_mk);
      m_st  = (m_st & ~((wr && off == 4'h0) ? ifc.csr_di[6:0] : 7'h0)) |
              {lnk_n != m_lp, read_exp, write_bar, hm_end, wr_to, tx_to, rx_to};
      if (wr && off == 4'h1) m_mk = ifc.csr_di[6:0];
      if (wr && off == 4'h2) m_bmp = ifc.csr_di;
      if (write_bar) m_lb = bar_num;
      if (wr && off == 4'h8) m_evt = any ? 1 : 0;
      else if (any && m_evt < EVT_MAX) m_evt = m_evt + 1;
      m_lp = lnk_n;
      for (int k = 0; k < 3; k++) begin
        if (cnt_in[k] == m_prev[k]) m_snap[k] = cnt_in[k];
        m_prev[k] = cnt_in[k];
      end
    end
    @(posedge sys_clk);
    #1;
    check("model_do", ifc.csr_do, e_do);
    check("model_irq", {31'b0, irq}, {31'b0, e_irq});
    check("model_bmp", bar_bitmap, m_bmp);
  endtask

  initial begin
    set_bus(4'h0, 1'b1, 1'b0, 32'h0);
    set_pul(6'h0);
    lnk_n = 1'b1; st_rx = 3'h0; st_tx = 2'h0; st = 2'h0; bar_num = 5'd3;
    cpt_rx = 0; cpt_tx = 0; cpt_drop = 0;
    sys_rst = 1'b1;
    #1;
    cyc(); cyc();
    sys_rst = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_bmp", bar_bitmap, 32'h0);
    check("rst_do", ifc.csr_do, 32'h0);

    // Reset readback; STATE shows the live lnk_up_n input (held at 1) in bit 7.
    for (int o = 0; o < 9; o++)
      add(4'(o), 1, 0, 0, 0, 1, 0, 1, (o == 3) ? 32'h80 : 32'h0, 1, 0);
    // BAR bitmap write and readback
    add(2, 1, 1, 32'hA5A5_0003, 0, 1, 0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 1, 0, 1, 32'hA5A5_0003, 1, 0);
    // Mask hm_end, pulse it, clear with a colliding pulse, clear again
    add(1, 1, 1, 32'h8, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 6'b001000, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 32'h8, 1, 1);
    add(0, 1, 1, 32'h8, 6'b001000, 1, 0, 1, 32'h8, 1, 1);
    add(0, 1, 0, 0, 0, 1, 0, 1, 32'h8, 1, 1);
    add(0, 1, 1, 32'h8, 0, 1, 0, 1, 32'h8, 1, 1);
    add(0, 1, 0, 0, 0, 1, 0, 1, 32'h0, 1, 0);
    // Counter filter: skewed 0x0001_FFFF must never be captured
    add(4, 1, 0, 0, 0, 1, 32'h0000_FFFF, 1, 32'h0, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0000_FFFF, 1, 32'h0, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0000_FFFF, 1, 32'h0000_FFFF, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0001_FFFF, 1, 32'h0000_FFFF, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0001_0000, 1, 32'h0000_FFFF, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0001_0000, 1, 32'h0000_FFFF, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0001_0000, 1, 32'h0001_0000, 0, 0);
    add(4, 1, 0, 0, 0, 1, 32'h0001_0000, 1, 32'h0001_0000, 0, 0);
    // Link edge, write_bar latch, RO write ignored, bank miss
    add(0, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'h0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'h40, 0, 0);
    add(0, 1, 0, 0, 6'b010000, 0, 32'h0001_0000, 1, 32'h40, 0, 0);
    add(7, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'h3, 0, 0);
    add(0, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'h50, 1, 0);
    add(7, 1, 1, 32'h1F, 0, 0, 32'h0001_0000, 0, 0, 0, 0);
    add(7, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'h3, 0, 0);
    add(2, 0, 1, 32'h0, 0, 0, 32'h0001_0000, 1, 32'h0, 0, 0);
    add(1, 0, 1, 32'h7F, 0, 0, 32'h0001_0000, 1, 32'h0, 0, 0);
    add(2, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'hA5A5_0003, 0, 0);
    add(1, 1, 0, 0, 0, 0, 32'h0001_0000, 1, 32'h8, 1, 0);

    for (int i = 0; i < nv; i++) begin
      set_bus(tv[i].off, tv[i].hit, tv[i].we, tv[i].di);
      set_pul(tv[i].pul);
      lnk_n  = tv[i].lnk;
      cpt_rx = tv[i].rx;
      cyc();
      if (tv[i].chk_do) check($sformatf("row%0d_do", i), ifc.csr_do, tv[i].exp_do);
      if (tv[i].chk_irq) check($sformatf("row%0d_irq", i), {31'b0, irq}, {31'b0, tv[i].exp_irq});
    end
    check("bmp_after_miss", bar_bitmap, 32'hA5A5_0003);

    // EVT_CNT saturation and clear behaviour
    set_pul(6'h0);
    set_bus(0, 1, 1, 32'h7F); cyc();
    set_bus(8, 1, 1, 32'h0); cyc();
    set_bus(8, 1, 0, 32'h0);
    for (int i = 0; i < 20; i++) begin set_pul(6'b000010); cyc(); end
    set_pul(6'h0); cyc();
    check("evt_sat", ifc.csr_do, 32'd15);
    set_bus(8, 1, 1, 32'hFFFF); set_pul(6'b000010); cyc();
    set_bus(8, 1, 0, 32'h0); set_pul(6'h0); cyc();
    check("evt_clr_pulse", ifc.csr_do, 32'd1);
    set_bus(8, 1, 1, 32'h0); cyc();
    set_bus(8, 1, 0, 32'h0); cyc();
    check("evt_clr", ifc.csr_do, 32'd0);

    // Random traffic against the model, with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      sys_rst = ($urandom_range(0, 199) == 0);
      set_bus(4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0,
              $urandom_range(0, 3) == 0, $urandom);
      set_pul(6'($urandom) & 6'($urandom) & 6'($urandom));
      if ($urandom_range(0, 15) == 0) lnk_n = ~lnk_n;
      st_rx = 3'($urandom); st_tx = 2'($urandom); st = 2'($urandom);
      bar_num = 5'($urandom);
      case ($urandom_range(0, 5))
        0: cpt_rx = cpt_rx + 1;
        1: cpt_tx = $urandom;
        2: cpt_drop = cpt_drop ^ (32'h1 << $urandom_range(0, 31));
        default: ;
      endcase
      cyc();
    end
    sys_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
